// File: rtl/riscv_pipe_ctrl_pkg.sv
// Shared encodings and control-word layout for the pipelined RV32I control unit.
// Holds opcodes, ALU/immediate/result codes and the branch-condition helper.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Native width of the ALU operation code; wider output ports are zero-padded.
    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       jalr_sel;
        logic       branch;
        logic       alu_src;
        alu_op_e    alu_control;
        logic [2:0] funct3;
    } ctrl_word_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } mem_word_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } wb_word_t;

    // funct3 bit 0 inverts the base condition selected by bits [2:1].
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic zero, input logic lt,
                                          input logic ltu);
        logic base;
        case (funct3[2:1])
            2'b00:   base = zero;
            2'b10:   base = lt;
            2'b11:   base = ltu;
            default: return 1'b0;
        endcase
        return base ^ funct3[0];
    endfunction

endpackage

// File: rtl/riscv_pipe_ctrl_if.sv
// Decode-side inputs and per-stage control outputs of the pipelined control unit.
interface riscv_pipe_ctrl_if #(
    parameter int ALU_CTRL_W = 4,
    parameter int IMM_SRC_W  = 3
);
    logic [6:0]            opD;
    logic [2:0]            funct3D;
    logic                  funct7b5D;
    logic                  FlushE;
    logic                  ZeroE;
    logic                  LtE;
    logic                  LtuE;
    logic [IMM_SRC_W-1:0]  ImmSrcD;
    logic                  IllegalD;
    logic [ALU_CTRL_W-1:0] ALUControlE;
    logic                  ALUSrcE;
    logic                  PCSrcE;
    logic                  PCTgtSrcE;
    logic                  RegWriteE;
    logic                  RegWriteM;
    logic                  RegWriteW;
    logic [1:0]            ResultSrcE;
    logic [1:0]            ResultSrcM;
    logic [1:0]            ResultSrcW;
    logic                  MemWriteM;

    modport master (
        output opD, funct3D, funct7b5D, FlushE, ZeroE, LtE, LtuE,
        input  ImmSrcD, IllegalD, ALUControlE, ALUSrcE, PCSrcE, PCTgtSrcE,
        input  RegWriteE, RegWriteM, RegWriteW,
        input  ResultSrcE, ResultSrcM, ResultSrcW, MemWriteM
    );

    modport slave (
        input  opD, funct3D, funct7b5D, FlushE, ZeroE, LtE, LtuE,
        output ImmSrcD, IllegalD, ALUControlE, ALUSrcE, PCSrcE, PCTgtSrcE,
        output RegWriteE, RegWriteM, RegWriteW,
        output ResultSrcE, ResultSrcM, ResultSrcW, MemWriteM
    );
endinterface

// File: rtl/riscv_pipe_ctrl_decode.sv
// Combinational main decoder + ALU decoder; illegal encodings collapse to a bubble.
module riscv_ctrl_decode
    import riscv_ctrl_pkg::*;
#(
    parameter bit BRANCH_EXT = 1'b1,
    parameter int IMM_SRC_W  = 3
) (
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    output ctrl_word_t           ctrl,
    output logic [IMM_SRC_W-1:0] imm_src,
    output logic                 illegal
);
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    ctrl_word_t cw;
    logic [1:0] alu_op;
    logic [2:0] imm_sel;
    logic       bad;
    alu_op_e    funct_op;

    always_comb begin
        funct_op = ALU_ADD;
        case (funct3)
            3'b000:  funct_op = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  funct_op = ALU_SLL;
            3'b010:  funct_op = ALU_SLT;
            3'b011:  funct_op = ALU_SLTU;
            3'b100:  funct_op = ALU_XOR;
            3'b101:  funct_op = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  funct_op = ALU_OR;
            default: funct_op = ALU_AND;
        endcase
    end

    always_comb begin
        cw      = '0;
        alu_op  = ALUOP_ADD;
        imm_sel = IMM_I;
        bad     = 1'b0;
        case (op)
            OP_LOAD: begin
                cw.reg_write  = 1'b1;
                cw.alu_src    = 1'b1;
                cw.result_src = RES_MEM;
            end
            OP_STORE: begin
                cw.mem_write = 1'b1;
                cw.alu_src   = 1'b1;
                imm_sel      = IMM_S;
            end
            OP_RTYPE: begin
                cw.reg_write = 1'b1;
                alu_op       = ALUOP_FUNCT;
            end
            OP_IALU: begin
                cw.reg_write = 1'b1;
                cw.alu_src   = 1'b1;
                alu_op       = ALUOP_FUNCT;
            end
            OP_BRANCH: begin
                cw.branch = 1'b1;
                imm_sel   = IMM_B;
                alu_op    = ALUOP_SUB;
                bad       = (funct3[2:1] == 2'b01) || (!BRANCH_EXT && funct3 != 3'b000);
            end
            OP_JAL: begin
                cw.jump       = 1'b1;
                cw.reg_write  = 1'b1;
                cw.result_src = RES_PC4;
                imm_sel       = IMM_J;
            end
            OP_JALR: begin
                cw.jump       = 1'b1;
                cw.jalr_sel   = 1'b1;
                cw.reg_write  = 1'b1;
                cw.alu_src    = 1'b1;
                cw.result_src = RES_PC4;
            end
            OP_LUI: begin
                cw.reg_write  = 1'b1;
                cw.result_src = RES_IMM;
                imm_sel       = IMM_U;
            end
            default: bad = 1'b1;
        endcase
        case (alu_op)
            ALUOP_SUB:   cw.alu_control = ALU_SUB;
            ALUOP_FUNCT: cw.alu_control = funct_op;
            default:     cw.alu_control = ALU_ADD;
        endcase
        cw.funct3 = funct3;
    end

    assign ctrl    = bad ? '0 : cw;
    assign imm_src = IMM_SRC_W'(imm_sel);
    assign illegal = bad;

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// Pipelined RV32I control: decode, E/M/W control registers and branch resolution in E.
module riscv_pipe_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4,
    parameter bit BRANCH_EXT = 1'b1,
    parameter int IMM_SRC_W  = 3
) (
    input logic              clk,
    input logic              reset,
    riscv_pipe_ctrl_if.slave bus
);
    ctrl_word_t d_ctrl;
    ctrl_word_t e_next;
    ctrl_word_t e_reg;
    mem_word_t  m_reg;
    wb_word_t   w_reg;
    logic [ALU_OP_W-1:0] alu_bits_e;

    riscv_ctrl_decode #(
        .BRANCH_EXT (BRANCH_EXT),
        .IMM_SRC_W  (IMM_SRC_W)
    ) u_decode (
        .op       (bus.opD),
        .funct3   (bus.funct3D),
        .funct7b5 (bus.funct7b5D),
        .ctrl     (d_ctrl),
        .imm_src  (bus.ImmSrcD),
        .illegal  (bus.IllegalD)
    );

    always_comb begin
        e_next = d_ctrl;
        if (bus.FlushE)
            e_next = '0;
    end

    // All three stages clear together so a reset mid-stream never lets a write through.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_reg <= '0;
            m_reg <= '0;
            w_reg <= '0;
        end else begin
            e_reg <= e_next;
            m_reg <= '{reg_write: e_reg.reg_write, result_src: e_reg.result_src,
                       mem_write: e_reg.mem_write};
            w_reg <= '{reg_write: m_reg.reg_write, result_src: m_reg.result_src};
        end
    end

    assign alu_bits_e      = e_reg.alu_control;
    assign bus.ALUControlE = ALU_CTRL_W'(alu_bits_e);
    assign bus.ALUSrcE     = e_reg.alu_src;
    assign bus.PCSrcE      = e_reg.jump ||
                             (e_reg.branch && branch_taken(e_reg.funct3, bus.ZeroE,
                                                           bus.LtE, bus.LtuE));
    assign bus.PCTgtSrcE   = e_reg.jalr_sel;
    assign bus.RegWriteE   = e_reg.reg_write;
    assign bus.ResultSrcE  = e_reg.result_src;
    assign bus.RegWriteM   = m_reg.reg_write;
    assign bus.ResultSrcM  = m_reg.result_src;
    assign bus.MemWriteM   = m_reg.mem_write;
    assign bus.RegWriteW   = w_reg.reg_write;
    assign bus.ResultSrcW  = w_reg.result_src;

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Directed bench: vector table for decode/E-stage behaviour plus hand sequences for pipeline timing.
module tb_riscv_pipe_ctrl;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] IA = 7'b0010011;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] JL = 7'b1101111;
    localparam logic [6:0] JR = 7'b1100111;
    localparam logic [6:0] LW = 7'b0000011;
    localparam logic [6:0] SW = 7'b0100011;
    localparam logic [6:0] LU = 7'b0110111;
    localparam logic [6:0] AU = 7'b0010111;
    localparam logic [6:0] XX = 7'b1111111;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    riscv_pipe_ctrl_if #(.ALU_CTRL_W(4), .IMM_SRC_W(3)) bus_a ();
    riscv_pipe_ctrl_if #(.ALU_CTRL_W(4), .IMM_SRC_W(3)) bus_b ();

    riscv_pipe_ctrl #(.ALU_CTRL_W(4), .BRANCH_EXT(1'b1), .IMM_SRC_W(3)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    riscv_pipe_ctrl #(.ALU_CTRL_W(4), .BRANCH_EXT(1'b0), .IMM_SRC_W(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    assign bus_b.opD       = bus_a.opD;
    assign bus_b.funct3D   = bus_a.funct3D;
    assign bus_b.funct7b5D = bus_a.funct7b5D;
    assign bus_b.FlushE    = bus_a.FlushE;
    assign bus_b.ZeroE     = bus_a.ZeroE;
    assign bus_b.LtE       = bus_a.LtE;
    assign bus_b.LtuE      = bus_a.LtuE;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       flush;
        logic       zero;
        logic       lt;
        logic       ltu;
        logic       chk_imm;
        logic [2:0] imm;
        logic       ill;
        logic [3:0] alu;
        logic       pcsrc;
        logic       tgt;
        logic       rw;
        logic [1:0] rs;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic flush, input logic zero, input logic lt,
                           input logic ltu, input logic chk_imm, input logic [2:0] imm,
                           input logic ill, input logic [3:0] alu, input logic pcsrc,
                           input logic tgt, input logic rw, input logic [1:0] rs);
        vec_t v;
        v = '{op, f3, f7, flush, zero, lt, ltu, chk_imm, imm, ill, alu, pcsrc, tgt, rw, rs};
        vq.push_back(v);
    endtask

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic flush);
        bus_a.opD       = op;
        bus_a.funct3D   = f3;
        bus_a.funct7b5D = f7;
        bus_a.FlushE    = flush;
        bus_a.ZeroE     = 1'b0;
        bus_a.LtE       = 1'b0;
        bus_a.LtuE      = 1'b0;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic flush);
        drive(op, f3, f7, flush);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic ill_b;
        logic pc_b;

        //      op  f3      f7    fl    z     lt    ltu   ci    imm   ill   alu   pc    tgt   rw    rs
        add_vec(R,  3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00);
        add_vec(R,  3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1, 2'b00);
        add_vec(IA, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1, 2'b00);
        add_vec(IA, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1, 2'b00);
        add_vec(IA, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00);
        add_vec(R,  3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 2'b00);
        add_vec(R,  3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b1, 2'b00);
        add_vec(R,  3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1, 2'b00);
        add_vec(R,  3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b1, 2'b00);
        add_vec(R,  3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1, 2'b00);
        add_vec(R,  3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 2'b00);
        add_vec(BR, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 2'b00);
        add_vec(BR, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        add_vec(BR, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        add_vec(BR, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 2'b00);
        add_vec(BR, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 2'b00);
        add_vec(BR, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        add_vec(BR, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 2'b00);
        add_vec(BR, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 2'b00);
        add_vec(BR, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        add_vec(BR, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        add_vec(BR, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        add_vec(JL, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 2'b10);
        add_vec(JR, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 2'b10);
        add_vec(JR, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        add_vec(LW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b01);
        add_vec(SW, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        add_vec(LU, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'b11);
        add_vec(XX, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        add_vec(AU, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
        add_vec(BR, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);

        // Reset held two cycles with an R-type on the decode inputs.
        reset = 1'b1;
        drive(R, 3'd0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_rwE",  bus_a.RegWriteE,   0);
        check("rst_rwM",  bus_a.RegWriteM,   0);
        check("rst_rwW",  bus_a.RegWriteW,   0);
        check("rst_rsE",  bus_a.ResultSrcE,  0);
        check("rst_rsW",  bus_a.ResultSrcW,  0);
        check("rst_aluE", bus_a.ALUControlE, 0);
        check("rst_memM", bus_a.MemWriteM,   0);
        check("rst_pcE",  bus_a.PCSrcE,      0);
        $display("[TB] reset held 2 cycles: stage outputs checked");
        reset = 1'b0;
        issue(R, 3'd0, 1'b0, 1'b0);
        check("rel_rwE", bus_a.RegWriteE, 1);
        check("rel_rwM", bus_a.RegWriteM, 0);
        $display("[TB] reset released: RegWriteE=%0b", bus_a.RegWriteE);

        // Vector table: decode outputs before the edge, E-stage outputs after it.
        foreach (vq[i]) begin
            drive(vq[i].op, vq[i].f3, vq[i].f7, vq[i].flush);
            bus_a.ZeroE = vq[i].zero;
            bus_a.LtE   = vq[i].lt;
            bus_a.LtuE  = vq[i].ltu;
            ill_b = vq[i].ill || (vq[i].op == BR && vq[i].f3 != 3'd0);
            pc_b  = ill_b ? 1'b0 : vq[i].pcsrc;
            #1;
            check($sformatf("v%0d_ill", i), bus_a.IllegalD, vq[i].ill);
            check($sformatf("v%0d_illb", i), bus_b.IllegalD, ill_b);
            if (vq[i].chk_imm)
                check($sformatf("v%0d_imm", i), bus_a.ImmSrcD, vq[i].imm);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_alu", i), bus_a.ALUControlE, vq[i].alu);
            check($sformatf("v%0d_pc", i),  bus_a.PCSrcE,      vq[i].pcsrc);
            check($sformatf("v%0d_pcb", i), bus_b.PCSrcE,      pc_b);
            check($sformatf("v%0d_tgt", i), bus_a.PCTgtSrcE,   vq[i].tgt);
            check($sformatf("v%0d_rw", i),  bus_a.RegWriteE,   vq[i].rw);
            check($sformatf("v%0d_rs", i),  bus_a.ResultSrcE,  vq[i].rs);
            $display("[TB] vec %0d op=%b f3=%0d fl=%0b: alu=%0d pc=%0b rw=%0b rs=%b ill=%0b",
                     i, vq[i].op, vq[i].f3, vq[i].flush, bus_a.ALUControlE,
                     bus_a.PCSrcE, bus_a.RegWriteE, bus_a.ResultSrcE, bus_a.IllegalD);
        end

        // add, sub, srai back to back; each reaches W three edges after issue.
        repeat (3) issue(XX, 3'd0, 1'b0, 1'b0);
        check("arith_w0", bus_a.RegWriteW, 0);
        issue(R, 3'd0, 1'b0, 1'b0);
        check("arith_add", bus_a.ALUControlE, 0);
        issue(R, 3'd0, 1'b1, 1'b0);
        check("arith_sub", bus_a.ALUControlE, 1);
        check("arith_w1", bus_a.RegWriteW, 0);
        issue(IA, 3'd5, 1'b1, 1'b0);
        check("arith_sra", bus_a.ALUControlE, 9);
        check("arith_w_add", bus_a.RegWriteW, 1);
        issue(XX, 3'd0, 1'b0, 1'b0);
        check("arith_w_sub", bus_a.RegWriteW, 1);
        issue(XX, 3'd0, 1'b0, 1'b0);
        check("arith_w_sra", bus_a.RegWriteW, 1);
        issue(XX, 3'd0, 1'b0, 1'b0);
        check("arith_w_bub", bus_a.RegWriteW, 0);
        $display("[TB] arithmetic sequence: RegWriteW latency checked");

        // Store reaches M two edges after issue.
        issue(SW, 3'd2, 1'b0, 1'b0);
        check("sw_memM0", bus_a.MemWriteM, 0);
        issue(XX, 3'd0, 1'b0, 1'b0);
        check("sw_memM", bus_a.MemWriteM, 1);
        check("sw_rwM",  bus_a.RegWriteM, 0);
        issue(XX, 3'd0, 1'b0, 1'b0);
        check("sw_memM_off", bus_a.MemWriteM, 0);
        $display("[TB] store sequence: MemWriteM=%0b", bus_a.MemWriteM);

        // jalr reaches W with ResultSrc=PC+4; flushed jalr leaves nothing in M.
        issue(JR, 3'd0, 1'b0, 1'b0);
        check("jalr_pc",  bus_a.PCSrcE,    1);
        check("jalr_tgt", bus_a.PCTgtSrcE, 1);
        issue(XX, 3'd0, 1'b0, 1'b0);
        issue(XX, 3'd0, 1'b0, 1'b0);
        check("jalr_rsW", bus_a.ResultSrcW, 2'b10);
        check("jalr_rwW", bus_a.RegWriteW,  1);
        issue(JR, 3'd0, 1'b0, 1'b1);
        check("jalrf_pc", bus_a.PCSrcE, 0);
        issue(XX, 3'd0, 1'b0, 1'b0);
        check("jalrf_rwM", bus_a.RegWriteM, 0);
        $display("[TB] jalr sequence: ResultSrcW path and flush checked");

        // Load-use: lw then a flushed consumer; the bubble must not write in W.
        issue(LW, 3'd2, 1'b0, 1'b0);
        check("lw_rsE", bus_a.ResultSrcE, 2'b01);
        check("lw_rwE", bus_a.RegWriteE,  1);
        issue(R, 3'd0, 1'b0, 1'b1);
        check("lu_rwE", bus_a.RegWriteE, 0);
        issue(XX, 3'd0, 1'b0, 1'b0);
        check("lw_rsW", bus_a.ResultSrcW, 2'b01);
        check("lw_rwW", bus_a.RegWriteW,  1);
        issue(XX, 3'd0, 1'b0, 1'b0);
        check("lu_rwW", bus_a.RegWriteW, 0);
        $display("[TB] load-use sequence: bubble RegWriteW=%0b", bus_a.RegWriteW);

        // Illegal opcode behind a valid add stays inert through every stage.
        issue(R, 3'd0, 1'b0, 1'b0);
        issue(XX, 3'd0, 1'b0, 1'b0);
        check("ill_rwE", bus_a.RegWriteE, 0);
        issue(LU, 3'd0, 1'b0, 1'b0);
        check("ill_rwM",  bus_a.RegWriteM, 0);
        check("ill_memM", bus_a.MemWriteM, 0);
        issue(LU, 3'd0, 1'b0, 1'b0);
        check("ill_rwW", bus_a.RegWriteW, 0);
        $display("[TB] illegal opcode sequence: stage writes checked");

        // Reset mid-stream with valid writes in E, M and W clears all at once.
        issue(R, 3'd0, 1'b0, 1'b0);
        issue(R, 3'd0, 1'b0, 1'b0);
        issue(R, 3'd0, 1'b0, 1'b0);
        check("mid_rwW_pre", bus_a.RegWriteW, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rwE", bus_a.RegWriteE, 0);
        check("mid_rwM", bus_a.RegWriteM, 0);
        check("mid_rwW", bus_a.RegWriteW, 0);
        reset = 1'b0;
        $display("[TB] mid-stream reset: all stages cleared");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
